// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SDRAM controller port between the CPU and the
// text-mode video adapter. It runs one transaction at a time. Video has
// priority, and a starvation guard makes sure the CPU is still served. A
// watchdog aborts transactions that the controller never finishes.
//
// Ports:
//   clock, reset                 clock; asynchronous active-high reset
//   cpu_req/we/be/addr/wdata     CPU request channel (held until cpu_ack)
//   cpu_rdata, cpu_ack           CPU read data (held) and completion pulse
//   vid_req/addr                 video read request channel
//   vid_rdata, vid_ack           video read data (held) and completion pulse
//   mem_req/we/be/addr/wdata     request to SDRAM controller (level until done)
//   mem_rdata, mem_done          controller read data and completion pulse
//   owner                        00 none, 01 cpu, 10 video
//   err                          sticky watchdog-timeout flag
module mem_arbiter #(
    parameter int unsigned AW      = 22,
    parameter int unsigned DW      = 16,
    parameter int unsigned VID_MAX = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [1:0]    cpu_be,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_rdata,
    output logic          vid_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [1:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_done,
    output logic [1:0]    owner,
    output logic          err
);

    localparam int unsigned VCW = $clog2(VID_MAX + 1);
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE = 2'b00, OWN_CPU = 2'b01, OWN_VID = 2'b10} owner_t;

    state_t          state_q, state_d;
    owner_t          own_q, own_d;
    logic            mreq_q, mreq_d;
    logic            we_q, we_d;
    logic [1:0]      be_q, be_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   cpu_rd_q, cpu_rd_d;
    logic [DW-1:0]   vid_rd_q, vid_rd_d;
    logic            err_q, err_d;
    logic [VCW-1:0]  vcnt_q, vcnt_d;
    logic [WDW-1:0]  wdog_q, wdog_d;
    logic            grant_vid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            own_q    <= OWN_NONE;
            mreq_q   <= 1'b0;
            we_q     <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cpu_rd_q <= '0;
            vid_rd_q <= '0;
            err_q    <= 1'b0;
            vcnt_q   <= '0;
            wdog_q   <= '0;
        end else begin
            state_q  <= state_d;
            own_q    <= own_d;
            mreq_q   <= mreq_d;
            we_q     <= we_d;
            be_q     <= be_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cpu_rd_q <= cpu_rd_d;
            vid_rd_q <= vid_rd_d;
            err_q    <= err_d;
            vcnt_q   <= vcnt_d;
            wdog_q   <= wdog_d;
        end
    end

    // Video wins unless the CPU has already waited through VID_MAX video grants.
    assign grant_vid = vid_req && !(cpu_req && (vcnt_q == VCW'(VID_MAX)));

    always_comb begin
        state_d  = state_q;
        own_d    = own_q;
        mreq_d   = mreq_q;
        we_d     = we_q;
        be_d     = be_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cpu_rd_d = cpu_rd_q;
        vid_rd_d = vid_rd_q;
        err_d    = err_q;
        vcnt_d   = vcnt_q;
        wdog_d   = wdog_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req || vid_req) begin
                    if (grant_vid) begin
                        own_d   = OWN_VID;
                        we_d    = 1'b0;
                        be_d    = '1;
                        addr_d  = vid_addr;
                        wdata_d = '0;
                        // The streak only grows while the CPU is actually waiting.
                        vcnt_d  = cpu_req ? vcnt_q + VCW'(1) : '0;
                    end else begin
                        own_d   = OWN_CPU;
                        we_d    = cpu_we;
                        be_d    = cpu_be;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                        vcnt_d  = '0;
                    end
                    mreq_d  = 1'b1;
                    wdog_d  = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                // wdog_q holds the number of BUSY cycles already elapsed, so
                // TIMEOUT-1 here means this is the TIMEOUT-th BUSY cycle. A
                // completion in that same cycle takes precedence.
                if (mem_done) begin
                    if (!we_q) begin
                        if (own_q == OWN_VID) vid_rd_d = mem_rdata;
                        else                  cpu_rd_d = mem_rdata;
                    end
                    mreq_d  = 1'b0;
                    state_d = S_DONE;
                end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                    if (!we_q) begin
                        if (own_q == OWN_VID) vid_rd_d = '1;
                        else                  cpu_rd_d = '1;
                    end
                    mreq_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wdog_d = wdog_q + WDW'(1);
                end
            end
            S_DONE: begin
                own_d   = OWN_NONE;
                state_d = S_IDLE;
            end
            default: begin
                own_d   = OWN_NONE;
                mreq_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign cpu_ack   = (state_q == S_DONE) && (own_q == OWN_CPU);
    assign vid_ack   = (state_q == S_DONE) && (own_q == OWN_VID);
    assign cpu_rdata = cpu_rd_q;
    assign vid_rdata = vid_rd_q;
    assign mem_req   = mreq_q;
    assign mem_we    = we_q;
    assign mem_be    = be_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign owner     = own_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int AW      = 22;
    localparam int DW      = 16;
    localparam int VID_MAX = 4;
    localparam int TIMEOUT = 255;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [1:0]    cpu_be = '0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic [DW-1:0] vid_rdata;
    logic          vid_ack;
    logic          mem_req, mem_we;
    logic [1:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_done = 1'b0;
    logic [1:0]    owner;
    logic          err;

    always #50 clock = ~clock;

    mem_arbiter #(.AW(AW), .DW(DW), .VID_MAX(VID_MAX), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_ack(vid_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .owner(owner), .err(err)
    );

    int total = 0;
    int bad   = 0;

    // Transaction-level reference: is a transaction in flight, is this the
    // acknowledge cycle, who owns it, and what was captured at grant.
    bit            m_busy, m_ack, m_err;
    int            m_own;      // 0 none, 1 cpu, 2 video
    int            m_wait;     // BUSY cycles consumed by the current transaction
    int            m_streak;   // video grants in a row while the CPU waited
    logic [AW-1:0] m_addr;
    logic          m_we;
    logic [1:0]    m_be;
    logic [DW-1:0] m_wdata, m_cpu_rd, m_vid_rd;

    // Controller behaviour: 0 random latency, 1 fixed latency/data, 2 never answer.
    int            ctl_mode = 1;
    int            ctl_lat  = 0;
    logic [DW-1:0] ctl_data = '0;
    bit            stray_en = 1'b0;
    bit            armed    = 1'b0;
    int            cnt      = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endfunction

    task automatic model_step();
        logic [DW-1:0] v;
        bit            gv;
        if (reset) begin
            m_busy = 0; m_ack = 0; m_err = 0; m_own = 0; m_wait = 0; m_streak = 0;
            m_addr = '0; m_we = 0; m_be = '0; m_wdata = '0; m_cpu_rd = '0; m_vid_rd = '0;
            return;
        end
        if (m_ack) begin
            m_ack = 0;
            m_own = 0;
        end else if (m_busy) begin
            m_wait++;
            if (mem_done || m_wait >= TIMEOUT) begin
                v = mem_done ? mem_rdata : '1;
                if (!mem_done) m_err = 1;
                if (!m_we) begin
                    if (m_own == 1) m_cpu_rd = v;
                    else            m_vid_rd = v;
                end
                m_busy = 0;
                m_ack  = 1;
            end
        end else if (cpu_req || vid_req) begin
            gv = vid_req && !(cpu_req && m_streak >= VID_MAX);
            m_streak = (gv && cpu_req) ? m_streak + 1 : 0;
            if (gv) begin
                m_own = 2; m_addr = vid_addr; m_we = 0; m_be = 2'b11; m_wdata = '0;
            end else begin
                m_own = 1; m_addr = cpu_addr; m_we = cpu_we; m_be = cpu_be; m_wdata = cpu_wdata;
            end
            m_busy = 1;
            m_wait = 0;
        end
    endtask

    task automatic compare();
        logic [1:0] eo;
        eo = (m_own == 1) ? 2'b01 : (m_own == 2) ? 2'b10 : 2'b00;
        chk("owner", owner, eo);
        chk("mem_req", mem_req, m_busy);
        chk("cpu_ack", cpu_ack, m_ack && m_own == 1);
        chk("vid_ack", vid_ack, m_ack && m_own == 2);
        chk("ack_exclusive", cpu_ack & vid_ack, 0);
        chk("cpu_rdata", cpu_rdata, m_cpu_rd);
        chk("vid_rdata", vid_rdata, m_vid_rd);
        chk("err", err, m_err);
        if (m_own != 0) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", mem_we, m_we);
            chk("mem_be", mem_be, m_be);
            chk("mem_wdata", mem_wdata, m_wdata);
        end
    endtask

    task automatic ctl();
        if (m_busy) begin
            if (!armed) begin
                armed = 1;
                cnt   = (ctl_mode == 0) ? int'($urandom_range(0, 5)) : ctl_lat;
            end
            if (ctl_mode != 2 && cnt == 0) begin
                mem_done  = 1;
                mem_rdata = (ctl_mode == 0) ? DW'($urandom) : ctl_data;
            end else begin
                mem_done = 0;
                if (cnt > 0) cnt--;
            end
        end else begin
            armed     = 0;
            mem_done  = stray_en && ($urandom_range(0, 7) == 0);
            mem_rdata = DW'($urandom);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare();
        ctl();
    endtask

    task automatic wait_ack(input bit vid, input int bound, output bit got);
        got = 0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (vid ? vid_ack : cpu_ack) begin
                got = 1;
                break;
            end
        end
    endtask

    task automatic new_cpu();
        cpu_req   = 1;
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_be    = 2'($urandom_range(0, 3));
        cpu_addr  = AW'($urandom);
        cpu_wdata = DW'($urandom);
    endtask

    task automatic rnd_req();
        if (m_ack && m_own == 1) begin
            if ($urandom_range(0, 1) == 0) cpu_req = 0;
            else                           new_cpu();
        end else if (!cpu_req && $urandom_range(0, 2) == 0) begin
            new_cpu();
        end
        if (m_ack && m_own == 2) begin
            if ($urandom_range(0, 1) == 0) vid_req = 0;
            else                           vid_addr = AW'($urandom);
        end else if (!vid_req && $urandom_range(0, 2) == 0) begin
            vid_req  = 1;
            vid_addr = AW'($urandom);
        end
    endtask

    initial begin
        bit    got;
        int    n;
        int    cyc;
        string order;

        repeat (2) tick();
        chk("rst_owner", owner, 2'b00);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_err", err, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        reset = 0;
        tick();

        // CPU read, controller answers in the third BUSY cycle
        ctl_mode = 1; ctl_lat = 2; ctl_data = 16'hBEEF;
        cpu_req = 1; cpu_we = 0; cpu_be = 2'b11; cpu_addr = 22'h00100; cpu_wdata = '0;
        tick();
        chk("t1_owner", owner, 2'b01);
        chk("t1_addr", mem_addr, 22'h00100);
        chk("t1_we", mem_we, 0);
        chk("t1_mem_req", mem_req, 1);
        wait_ack(0, 20, got);
        chk("t1_ack_seen", got, 1);
        chk("t1_rdata", cpu_rdata, 16'hBEEF);
        cpu_req = 0;
        tick();
        chk("t1_owner_idle", owner, 2'b00);
        chk("t1_ack_one_cycle", cpu_ack, 0);

        // CPU write, low byte only
        cpu_req = 1; cpu_we = 1; cpu_be = 2'b01; cpu_addr = 22'h00200; cpu_wdata = 16'h12AB;
        tick();
        chk("t2_we", mem_we, 1);
        chk("t2_be", mem_be, 2'b01);
        chk("t2_wdata", mem_wdata, 16'h12AB);
        wait_ack(0, 20, got);
        chk("t2_ack_seen", got, 1);
        chk("t2_rdata_kept", cpu_rdata, 16'hBEEF);
        cpu_req = 0;
        tick();

        // Simultaneous requests: video first, CPU right after
        ctl_lat = 0; ctl_data = 16'h5A5A;
        vid_req = 1; vid_addr = 22'h30000;
        cpu_req = 1; cpu_we = 0; cpu_be = 2'b11; cpu_addr = 22'h00300;
        tick();
        chk("t3_first_owner", owner, 2'b10);
        chk("t3_vid_addr", mem_addr, 22'h30000);
        chk("t3_vid_be", mem_be, 2'b11);
        chk("t3_vid_wdata", mem_wdata, 0);
        wait_ack(1, 20, got);
        chk("t3_vid_ack_seen", got, 1);
        chk("t3_no_cpu_ack", cpu_ack, 0);
        chk("t3_vid_rdata", vid_rdata, 16'h5A5A);
        vid_req = 0;
        tick();
        tick();
        chk("t3_cpu_owner", owner, 2'b01);
        chk("t3_cpu_addr", mem_addr, 22'h00300);
        wait_ack(0, 20, got);
        chk("t3_cpu_ack_seen", got, 1);
        cpu_req = 0;
        tick();

        // Continuous contention: starvation guard pattern
        ctl_mode = 0;
        vid_req = 1; vid_addr = 22'h12345;
        cpu_req = 1; cpu_we = 0; cpu_be = 2'b11; cpu_addr = 22'h00777;
        order = ""; n = 0;
        for (int i = 0; i < 400 && n < 10; i++) begin
            tick();
            if (cpu_ack) begin order = {order, "C"}; n++; end
            else if (vid_ack) begin order = {order, "V"}; n++; end
        end
        total++;
        if (order != "VVVVCVVVVC") begin
            bad++;
            $display("FAIL t4_grant_order act=%s exp=VVVVCVVVVC", order);
        end
        cpu_req = 0; vid_req = 0;
        tick();

        // Completion in the very cycle the watchdog would expire
        ctl_mode = 1; ctl_lat = TIMEOUT - 1; ctl_data = 16'h0F0F;
        cpu_req = 1; cpu_we = 0; cpu_be = 2'b11; cpu_addr = 22'h00500;
        wait_ack(0, 400, got);
        chk("t5_ack_seen", got, 1);
        chk("t5_no_err", err, 0);
        chk("t5_rdata", cpu_rdata, 16'h0F0F);
        cpu_req = 0;
        tick();

        // Hung controller
        ctl_mode = 2;
        cpu_req = 1; cpu_we = 0; cpu_be = 2'b11; cpu_addr = 22'h00600;
        cyc = 0; got = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (mem_req) cyc++;
            if (cpu_ack) begin got = 1; break; end
        end
        chk("t6_ack_seen", got, 1);
        chk("t6_busy_cycles", cyc, TIMEOUT);
        chk("t6_err", err, 1);
        chk("t6_rdata", cpu_rdata, 16'hFFFF);
        chk("t6_mem_req_low", mem_req, 0);
        cpu_req = 0;
        tick();
        ctl_mode = 1; ctl_lat = 1;
        cpu_req = 1; cpu_we = 1; cpu_be = 2'b10; cpu_wdata = 16'h7777;
        wait_ack(0, 20, got);
        chk("t6b_ack_seen", got, 1);
        chk("t6b_err_sticky", err, 1);
        cpu_req = 0;
        tick();

        // Reset in the middle of a transaction
        ctl_mode = 2;
        cpu_req = 1; cpu_we = 0; cpu_be = 2'b11; cpu_addr = 22'h00700;
        repeat (5) tick();
        chk("t7_busy_before", mem_req, 1);
        reset = 1;
        #1;
        chk("t7_async_mem_req", mem_req, 0);
        chk("t7_async_owner", owner, 2'b00);
        chk("t7_async_err", err, 0);
        chk("t7_async_rdata", cpu_rdata, 0);
        chk("t7_async_ack", cpu_ack | vid_ack, 0);
        cpu_req = 0;
        ctl_mode = 1; ctl_lat = 3; ctl_data = 16'hC0DE;
        tick();
        tick();
        reset = 0;
        tick();
        cpu_req = 1; cpu_addr = 22'h00400;
        tick();
        chk("t7_fresh_owner", owner, 2'b01);
        wait_ack(0, 20, got);
        chk("t7_fresh_ack", got, 1);
        chk("t7_fresh_rdata", cpu_rdata, 16'hC0DE);
        cpu_req = 0;
        tick();

        // Randomised traffic with stray completions outside BUSY
        ctl_mode = 0;
        stray_en = 1;
        repeat (3000) begin
            tick();
            rnd_req();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
